// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths and types
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/wb_bypass_match.sv
// wb_bypass_match: newest-match search over age-ordered pending writes
module wb_bypass_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [REG_ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0]  q_reg,
  input  logic [DEPTH-1:0][DATA_W-1:0]      q_data,
  input  logic [DEPTH-1:0]                  q_vld,
  input  logic                              out_vld,
  input  logic [REG_ADDR_W-1:0]             out_reg,
  input  logic [DATA_W-1:0]                 out_data,
  output logic                              hit,
  output logic [DATA_W-1:0]                 data
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    if (addr != REG_ZERO) begin
      if (out_vld && out_reg == addr) begin
        hit = 1'b1;
        data = out_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i] && q_reg[i] == addr) begin
          hit = 1'b1;
          data = q_data[i];
        end
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: FIFO of pending register writebacks with decode bypass
module wb_write_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REG_ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         drain_en,
  output logic [REG_ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]            write_data,
  output logic                         RegWrite,
  input  logic [REG_ADDR_W-1:0]        read_reg1,
  input  logic [REG_ADDR_W-1:0]        read_reg2,
  output logic                         byp_hit1,
  output logic                         byp_hit2,
  output logic [DATA_W-1:0]            byp_data1,
  output logic [DATA_W-1:0]            byp_data2,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [REG_ADDR_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ord_reg;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;
  logic [DEPTH-1:0] ord_vld;
  assign in_ready = count < CW'(DEPTH);
  assign push = in_valid && in_ready && in_reg != REG_ZERO;
  assign pop = drain_en && count != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head <= '0;
      tail <= '0;
      RegWrite <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      RegWrite <= pop;
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head <= head + 1'b1;
        write_reg <= mem_reg[head];
        write_data <= mem_data[head];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_reg[tail] <= in_reg;
      mem_data[tail] <= in_data;
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_ord
    assign ord_reg[g] = mem_reg[head + PW'(g)];
    assign ord_data[g] = mem_data[head + PW'(g)];
    assign ord_vld[g] = CW'(g) < count;
  end
  wb_bypass_match #(.DEPTH(DEPTH)) u_match1 (
    .addr(read_reg1), .q_reg(ord_reg), .q_data(ord_data), .q_vld(ord_vld),
    .out_vld(RegWrite), .out_reg(write_reg), .out_data(write_data),
    .hit(byp_hit1), .data(byp_data1)
  );
  wb_bypass_match #(.DEPTH(DEPTH)) u_match2 (
    .addr(read_reg2), .q_reg(ord_reg), .q_data(ord_data), .q_vld(ord_vld),
    .out_vld(RegWrite), .out_reg(write_reg), .out_data(write_data),
    .hit(byp_hit2), .data(byp_data2)
  );
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed self-checking bench for wb_write_queue
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, drain_en, RegWrite, byp_hit1, byp_hit2;
  logic [4:0] in_reg, write_reg, read_reg1, read_reg2;
  logic [31:0] in_data, write_data, byp_data1, byp_data2;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2), .count(count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_reg = r;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_reg = '0;
    in_data = '0;
    drain_en = 1'b0;
    read_reg1 = '0;
    read_reg2 = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_wreg", 32'(write_reg), 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_hit1", 32'(byp_hit1), 0);
    chk("rst_data2", byp_data2, 0);
    drain_en = 1'b1;
    push(5'd3, 32'habcdef12);
    chk("lat_e_regwrite", 32'(RegWrite), 0);
    chk("lat_e_count", 32'(count), 1);
    tick();
    chk("lat_rw", 32'(RegWrite), 1);
    chk("lat_wreg", 32'(write_reg), 3);
    chk("lat_wdata", write_data, 32'habcdef12);
    tick();
    chk("lat_rw_off", 32'(RegWrite), 0);
    chk("lat_hold_wreg", 32'(write_reg), 3);
    chk("lat_hold_wdata", write_data, 32'habcdef12);
    chk("lat_count0", 32'(count), 0);
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(in_ready), 0);
    push(5'd5, 32'h55);
    chk("full_count_kept", 32'(count), 4);
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_rw", 32'(RegWrite), 1);
      chk("drain_wreg", 32'(write_reg), 32'(i));
      chk("drain_wdata", write_data, 32'(i * 32'h11));
    end
    chk("drain_count0", 32'(count), 0);
    tick();
    chk("drain_no_fifth", 32'(RegWrite), 0);
    drain_en = 1'b0;
    push(5'd5, 32'hA);
    push(5'd5, 32'hB);
    read_reg1 = 5'd5;
    read_reg2 = 5'd6;
    #1;
    chk("byp_hit1", 32'(byp_hit1), 1);
    chk("byp_data1", byp_data1, 32'hB);
    chk("byp_hit2", 32'(byp_hit2), 0);
    chk("byp_data2", byp_data2, 0);
    read_reg2 = 5'd5;
    #1;
    chk("byp_same_hit", 32'(byp_hit2), 1);
    chk("byp_same_data", byp_data2, 32'hB);
    drain_en = 1'b1;
    tick();
    chk("byp_prio_queue", byp_data1, 32'hB);
    tick();
    chk("byp_out_hit", 32'(byp_hit1), 1);
    chk("byp_out_data", byp_data1, 32'hB);
    tick();
    chk("byp_out_gone", 32'(byp_hit1), 0);
    chk("byp_out_gone_d", byp_data1, 0);
    drain_en = 1'b0;
    read_reg2 = '0;
    push(5'd0, 32'hdead);
    chk("r0_count", 32'(count), 0);
    read_reg1 = '0;
    #1;
    chk("r0_hit", 32'(byp_hit1), 0);
    drain_en = 1'b1;
    tick();
    chk("r0_no_write", 32'(RegWrite), 0);
    drain_en = 1'b0;
    push(5'd1, 32'h101);
    push(5'd2, 32'h102);
    chk("stream_count2", 32'(count), 2);
    drain_en = 1'b1;
    for (int r = 3; r <= 10; r++) begin
      push(5'(r), 32'h100 + 32'(r));
      chk("stream_count", 32'(count), 2);
      chk("stream_wreg", 32'(write_reg), 32'(r - 2));
      chk("stream_wdata", write_data, 32'h100 + 32'(r - 2));
    end
    for (int r = 9; r <= 10; r++) begin
      tick();
      chk("stream_tail_rw", 32'(RegWrite), 1);
      chk("stream_tail_wreg", 32'(write_reg), 32'(r));
    end
    tick();
    chk("stream_end_rw", 32'(RegWrite), 0);
    chk("stream_end_count", 32'(count), 0);
    drain_en = 1'b0;
    push(5'd7, 32'h7);
    push(5'd8, 32'h8);
    push(5'd9, 32'h9);
    chk("mid_count3", 32'(count), 3);
    reset = 1'b1;
    drain_en = 1'b1;
    in_valid = 1'b1;
    in_reg = 5'd12;
    in_data = 32'hc;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    read_reg1 = 5'd7;
    #1;
    chk("mid_rst_rw", 32'(RegWrite), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_wreg", 32'(write_reg), 0);
    chk("mid_rst_wdata", write_data, 0);
    chk("mid_rst_hit", 32'(byp_hit1), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_stale", 32'(RegWrite), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; a power of two, at least 2.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: a writeback result is offered.
REQ-005 SHALL have port in_ready, output, 1: the queue can accept a result this cycle.
REQ-006 SHALL have port in_reg, input, 5: destination register number.
REQ-007 SHALL have port in_data, input, 32: result value.
REQ-008 SHALL have port drain_en, input, 1: permits popping the head entry toward the register file.
REQ-009 SHALL have ports write_reg (output, 5), write_data (output, 32) and RegWrite (output, 1): the register-file write port.
REQ-010 SHALL have ports read_reg1 and read_reg2, input, 5 each: decode-stage read addresses to check for bypass.
REQ-011 SHALL have ports byp_hit1 and byp_hit2, output, 1 each: a pending write exists for the matching read address.
REQ-012 SHALL have ports byp_data1 and byp_data2, output, 32 each: the newest pending value for each read address.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-014 SHALL drive in_ready = (count < DEPTH), combinationally from registered state only; a full queue SHALL NOT pass a result through.
REQ-015 SHALL accept an entry on a rising edge where in_valid && in_ready, writing it at the tail pointer.
REQ-016 SHALL complete the handshake for an accepted entry with in_reg == 0 but SHALL NOT store it, change count, or ever produce a write for it.
REQ-017 SHALL pop the head entry on a rising edge where drain_en && count > 0, and register it onto write_reg/write_data with RegWrite = 1 for exactly that following cycle.
REQ-018 SHALL drive RegWrite = 0 in the cycle after any edge with no pop; write_reg/write_data SHALL hold their previous values in that cycle.
REQ-019 SHALL give a minimum latency of: accepted at edge E -> RegWrite = 1 in the cycle following edge E+1.
REQ-020 SHALL drain entries in strict acceptance order (FIFO); pointers SHALL wrap modulo DEPTH.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop; count SHALL never exceed DEPTH nor underflow.
REQ-022 SHALL compute bypass combinationally over all occupied entries plus the output register while RegWrite = 1.
REQ-023 SHALL resolve bypass priority as: newest queue entry (nearest tail) > older entries > output register.
REQ-024 SHALL return hit = 0 and data = 0 on a bypass miss, and for read address 0.
REQ-025 SHALL make both bypass ports independent; equal addresses SHALL give identical results.

Reset
REQ-026 SHALL, while reset = 1 at an edge, set count and both pointers to 0, RegWrite to 0, write_reg to 0 and write_data to 0.
REQ-027 SHALL have reset dominate in_valid and drain_en; entries pending mid-operation are discarded, with no RegWrite in the cycle after reset.
REQ-028 SHALL, after reset, drive in_ready = 1, byp_hit1/2 = 0 and byp_data1/2 = 0.

Structure
REQ-029 SHALL take REG_ADDR_W = 5, DATA_W = 32 and REG_ZERO = 5'd0 from the shared package mips_pkg.
REQ-030 SHALL place the per-port newest-match search in sub-module wb_bypass_match, instantiated twice.
REQ-031 SHALL keep storage as a register array with no tool-inferred RAM; reads are asynchronous for bypass.

Verification
REQ-032 SHALL cover: reset, drain_en = 1, enqueue (3, 0xabcdef12) -> exactly one RegWrite cycle with write_reg = 3 and write_data = 0xabcdef12, per REQ-019.
REQ-033 SHALL cover: drain_en = 0, enqueue regs 1..4 with data 0x11, 0x22, 0x33, 0x44 -> count = 4 and in_ready = 0; a fifth offer (5, 0x55) is ignored; then drain_en = 1 -> four consecutive RegWrite pulses in order 1, 2, 3, 4, then count = 0.
REQ-034 SHALL cover: drain_en = 0, enqueue (5, 0xA) then (5, 0xB), read_reg1 = 5, read_reg2 = 6 -> byp_hit1 = 1 with byp_data1 = 0xB; byp_hit2 = 0 with byp_data2 = 0.
REQ-035 SHALL cover: enqueue (0, 0xdead) -> accepted, count unchanged, no RegWrite; read_reg1 = 0 -> byp_hit1 = 0.
REQ-036 SHALL cover: count = 2 with push and pop on the same edge -> count stays 2; stream 10 entries (regs 1..10) across wrap -> written in order 1..10.
REQ-037 SHALL cover: count = 3, reset asserted for one cycle -> RegWrite = 0 next cycle, count = 0, and no stale write afterwards even with drain_en = 1.
